ddr_axi_burst_ctrl: RTL and testbench

Parametrised AXI-style DDR burst master for the shared-address-channel DDR port (DDR_AVALID/DDR_ATYPE/DDR_AREADY). It replaces single-register data paths with a write FIFO and a read FIFO. It generalises data width and buffer depth, gates bursts on buffer occupancy, and checks DDR_RLAST. It sits between the image-processing user logic and the DDR controller's AXI target.

---
 rtl/ddr_axi_pkg.sv | 28 ++
 rtl/sync_fwft_fifo.sv | 63 ++++++
 rtl/ddr_axi_burst_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_ddr_axi_burst_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_axi_pkg.sv
// Shared types and constants for the DDR AXI burst master.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum (encodings are visible on the top-level state
// port), the INCR burst code, the write/read address-type codes, and the
// AxSIZE helper.
package ddr_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } ddr_state_e;

  localparam logic [1:0] ABURST_INCR = 2'b01;
  localparam logic       ATYPE_WR    = 1'b1;
  localparam logic       ATYPE_RD    = 1'b0;

  // AxSIZE is log2 of the number of bytes per beat.
  function automatic logic [2:0] asize_of(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: push while full is dropped; pop while empty is ignored.
//
// Ports: clk, rst_n (async active-low; flushes the pointers); push/push_dat
// write side; pop/pop_dat read side (pop_dat is the head word); full, empty
// and count (0..DEPTH).
module sync_fwft_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // Full and empty are judged on the pre-edge state, so a push into a full
  // FIFO is dropped even if a pop happens in the same cycle.
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = cnt;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: contents are only observable through the
  // pointers, which are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ddr_axi_burst_ctrl.sv
// AXI-style DDR burst master: write FIFO -> W channel, R channel -> read FIFO.
// Latency: AVALID one cycle after request acceptance; usr_wr_done one cycle after the last B/R handshake.
// Backpressure: bursts start only when the FIFO holds/has room for the whole burst; RREADY drops when read FIFO full.
//
// Ports: AXI_CLK, usr_rstn (async active-low). User command side:
// usr_write/usr_read level requests with address and alen (beats-1),
// usr_cmd_ack / usr_cmd_err pulses. User data side: tx_buf_we/usr_data_in
// into the write FIFO (tx_buf_full), rx_buf_re/usr_data_out from the read
// FIFO (rx_buf_dvalid). Status: axi_bus_busy, usr_wr_done, sticky rlast_err,
// state. DDR side: shared A channel (AVALID/ATYPE/AREADY/AADR/ALEN/ASIZE/
// ABURST), W, B and R channels.
// Optional build macro DDRC_PERF_CNT_EN adds perf_wr_bursts, perf_rd_bursts
// and perf_stall_cyc wrapping counters.
module ddr_axi_burst_ctrl
  import ddr_axi_pkg::*;
#(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 32,
  parameter int WFIFO_DEPTH = 16,
  parameter int RFIFO_DEPTH = 16
) (
  input  logic                  AXI_CLK,
  input  logic                  usr_rstn,
  input  logic                  usr_write,
  input  logic                  usr_read,
  input  logic [ADDR_W-1:0]     usr_waddr_in,
  input  logic [7:0]            usr_wd_alen,
  input  logic [ADDR_W-1:0]     usr_raddr_in,
  input  logic [7:0]            usr_rd_alen,
  output logic                  usr_cmd_ack,
  output logic                  usr_cmd_err,
  input  logic                  tx_buf_we,
  input  logic [DATA_W-1:0]     usr_data_in,
  output logic                  tx_buf_full,
  input  logic                  rx_buf_re,
  output logic [DATA_W-1:0]     usr_data_out,
  output logic                  rx_buf_dvalid,
  output logic                  axi_bus_busy,
  output logic                  usr_wr_done,
  output logic                  rlast_err,
  output logic [2:0]            state,
  output logic                  DDR_AVALID,
  output logic                  DDR_ATYPE,
  input  logic                  DDR_AREADY,
  output logic [ADDR_W-1:0]     DDR_AADR,
  output logic [7:0]            DDR_ALEN,
  output logic [2:0]            DDR_ASIZE,
  output logic [1:0]            DDR_ABURST,
  output logic                  DDR_WVALID,
  output logic                  DDR_WLAST,
  input  logic                  DDR_WREADY,
  output logic [DATA_W-1:0]     DDR_WDATA,
  output logic [DATA_W/8-1:0]   DDR_WSTRB,
  input  logic                  DDR_BVALID,
  output logic                  DDR_BREADY,
  input  logic                  DDR_RVALID,
  input  logic                  DDR_RLAST,
  input  logic [DATA_W-1:0]     DDR_RDATA,
  output logic                  DDR_RREADY
`ifdef DDRC_PERF_CNT_EN
  ,
  output logic [31:0]           perf_wr_bursts,
  output logic [31:0]           perf_rd_bursts,
  output logic [31:0]           perf_stall_cyc
`endif
);

  localparam int WCW = $clog2(WFIFO_DEPTH) + 1;
  localparam int RCW = $clog2(RFIFO_DEPTH) + 1;

  ddr_state_e          state_q, state_d;
  logic                aval_q;
  logic                atype_q;
  logic [ADDR_W-1:0]   aadr_q;
  logic [7:0]          alen_q;
  logic [8:0]          beat_q;
  logic                b_seen_q;
  logic                ack_q;
  logic                err_q;
  logic                rlast_err_q;

  logic [WCW-1:0]      wcount;
  logic [RCW-1:0]      rcount;
  logic                wfull, wempty, rfull, rempty;

  logic [8:0]          wr_len, rd_len, rd_free;
  logic                wr_over, rd_over, wr_elig, rd_elig;
  logic                accept_wr, accept_rd, reject;
  logic                beat_last;
  logic                w_hs, r_hs, b_hs;

  // ---------------------------------------------------------------- FIFOs
  sync_fwft_fifo #(.WIDTH(DATA_W), .DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk      (AXI_CLK),
    .rst_n    (usr_rstn),
    .push     (tx_buf_we),
    .push_dat (usr_data_in),
    .pop      (w_hs),
    .pop_dat  (DDR_WDATA),
    .full     (wfull),
    .empty    (wempty),
    .count    (wcount)
  );

  sync_fwft_fifo #(.WIDTH(DATA_W), .DEPTH(RFIFO_DEPTH)) u_rfifo (
    .clk      (AXI_CLK),
    .rst_n    (usr_rstn),
    .push     (r_hs),
    .push_dat (DDR_RDATA),
    .pop      (rx_buf_re),
    .pop_dat  (usr_data_out),
    .full     (rfull),
    .empty    (rempty),
    .count    (rcount)
  );

  // ------------------------------------------------- request qualification
  // 9-bit lengths so that alen=255 means 256 beats without wrapping.
  assign wr_len  = {1'b0, usr_wd_alen} + 9'd1;
  assign rd_len  = {1'b0, usr_rd_alen} + 9'd1;
  assign rd_free = 9'(RFIFO_DEPTH) - 9'(rcount);
  assign wr_over = (wr_len > 9'(WFIFO_DEPTH));
  assign rd_over = (rd_len > 9'(RFIFO_DEPTH));
  assign wr_elig = usr_write & ~wr_over & (9'(wcount) >= wr_len);
  assign rd_elig = usr_read  & ~rd_over & (rd_free >= rd_len);

  assign beat_last = (beat_q == {1'b0, alen_q});
  assign w_hs      = DDR_WVALID & DDR_WREADY;
  assign r_hs      = DDR_RVALID & DDR_RREADY;
  assign b_hs      = DDR_BVALID & DDR_BREADY;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge AXI_CLK or negedge usr_rstn) begin
    if (!usr_rstn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    reject    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write has priority; an eligible read waits behind it. An oversized
        // request only raises an error when nothing else can be started.
        if (wr_elig) begin
          accept_wr = 1'b1;
          state_d   = ST_ADDR;
        end else if (rd_elig) begin
          accept_rd = 1'b1;
          state_d   = ST_ADDR;
        end else if ((usr_write & wr_over) | (usr_read & rd_over)) begin
          reject = 1'b1;
        end
      end
      ST_ADDR: begin
        if (aval_q & DDR_AREADY)
          state_d = (atype_q == ATYPE_WR) ? ST_WDATA : ST_RDATA;
      end
      ST_WDATA: begin
        if (w_hs & beat_last) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (b_seen_q | DDR_BVALID) state_d = ST_DONE;
      end
      ST_RDATA: begin
        // Leave on whichever comes first: RLAST or the expected beat count.
        if (r_hs & (DDR_RLAST | beat_last)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------ burst datapath
  always_ff @(posedge AXI_CLK or negedge usr_rstn) begin
    if (!usr_rstn) begin
      aval_q      <= 1'b0;
      atype_q     <= ATYPE_RD;
      aadr_q      <= '0;
      alen_q      <= '0;
      beat_q      <= '0;
      b_seen_q    <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rlast_err_q <= 1'b0;
    end else begin
      ack_q <= accept_wr | accept_rd;
      err_q <= reject;

      if (accept_wr | accept_rd) begin
        aval_q   <= 1'b1;
        atype_q  <= accept_wr ? ATYPE_WR : ATYPE_RD;
        aadr_q   <= accept_wr ? usr_waddr_in : usr_raddr_in;
        alen_q   <= accept_wr ? usr_wd_alen : usr_rd_alen;
        beat_q   <= '0;
        b_seen_q <= 1'b0;
      end else begin
        if (aval_q & DDR_AREADY) aval_q <= 1'b0;
        if (w_hs | r_hs)         beat_q <= beat_q + 9'd1;
        // A response arriving during WDATA is remembered for WRESP.
        if (b_hs)                b_seen_q <= 1'b1;
      end

      if (r_hs & (DDR_RLAST != beat_last)) rlast_err_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------- outputs
  assign state         = state_q;
  assign usr_cmd_ack   = ack_q;
  assign usr_cmd_err   = err_q;
  assign usr_wr_done   = (state_q == ST_DONE);
  assign axi_bus_busy  = (state_q != ST_IDLE);
  assign rlast_err     = rlast_err_q;
  assign tx_buf_full   = wfull;
  assign rx_buf_dvalid = ~rempty;

  assign DDR_AVALID = aval_q;
  assign DDR_ATYPE  = atype_q;
  assign DDR_AADR   = aadr_q;
  assign DDR_ALEN   = alen_q;
  assign DDR_ASIZE  = asize_of(DATA_W);
  assign DDR_ABURST = ABURST_INCR;
  assign DDR_WSTRB  = '1;

  // The acceptance check guarantees data for every beat; the empty term only
  // keeps a stale head word from ever being presented.
  assign DDR_WVALID = (state_q == ST_WDATA) & ~wempty;
  assign DDR_WLAST  = DDR_WVALID & beat_last;
  assign DDR_BREADY = (state_q == ST_WDATA) | (state_q == ST_WRESP);
  assign DDR_RREADY = (state_q == ST_RDATA) & ~rfull;

`ifdef DDRC_PERF_CNT_EN
  logic stall;
  assign stall = (DDR_AVALID & ~DDR_AREADY) |
                 (DDR_WVALID & ~DDR_WREADY) |
                 (DDR_RVALID & ~DDR_RREADY);

  always_ff @(posedge AXI_CLK or negedge usr_rstn) begin
    if (!usr_rstn) begin
      perf_wr_bursts <= '0;
      perf_rd_bursts <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (accept_wr) perf_wr_bursts <= perf_wr_bursts + 32'd1;
      if (accept_rd) perf_rd_bursts <= perf_rd_bursts + 32'd1;
      if (stall)     perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_axi_burst_ctrl.sv
// Directed-plus-random bench for ddr_axi_burst_ctrl: queue models of both
// FIFOs, a bench-side DDR target, and immediate assertions at every check.
module tb_ddr_axi_burst_ctrl;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int WD = 16;
  localparam int RD = 16;

  logic              AXI_CLK = 1'b0;
  logic              usr_rstn;
  logic              usr_write, usr_read;
  logic [AW-1:0]     usr_waddr_in, usr_raddr_in;
  logic [7:0]        usr_wd_alen, usr_rd_alen;
  logic              usr_cmd_ack, usr_cmd_err;
  logic              tx_buf_we;
  logic [DW-1:0]     usr_data_in;
  logic              tx_buf_full;
  logic              rx_buf_re;
  logic [DW-1:0]     usr_data_out;
  logic              rx_buf_dvalid, axi_bus_busy, usr_wr_done, rlast_err;
  logic [2:0]        state;
  logic              DDR_AVALID, DDR_ATYPE, DDR_AREADY;
  logic [AW-1:0]     DDR_AADR;
  logic [7:0]        DDR_ALEN;
  logic [2:0]        DDR_ASIZE;
  logic [1:0]        DDR_ABURST;
  logic              DDR_WVALID, DDR_WLAST, DDR_WREADY;
  logic [DW-1:0]     DDR_WDATA;
  logic [DW/8-1:0]   DDR_WSTRB;
  logic              DDR_BVALID, DDR_BREADY;
  logic              DDR_RVALID, DDR_RLAST, DDR_RREADY;
  logic [DW-1:0]     DDR_RDATA;

  ddr_axi_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WFIFO_DEPTH(WD), .RFIFO_DEPTH(RD)) dut (
    .AXI_CLK(AXI_CLK), .usr_rstn(usr_rstn),
    .usr_write(usr_write), .usr_read(usr_read),
    .usr_waddr_in(usr_waddr_in), .usr_wd_alen(usr_wd_alen),
    .usr_raddr_in(usr_raddr_in), .usr_rd_alen(usr_rd_alen),
    .usr_cmd_ack(usr_cmd_ack), .usr_cmd_err(usr_cmd_err),
    .tx_buf_we(tx_buf_we), .usr_data_in(usr_data_in), .tx_buf_full(tx_buf_full),
    .rx_buf_re(rx_buf_re), .usr_data_out(usr_data_out), .rx_buf_dvalid(rx_buf_dvalid),
    .axi_bus_busy(axi_bus_busy), .usr_wr_done(usr_wr_done), .rlast_err(rlast_err),
    .state(state),
    .DDR_AVALID(DDR_AVALID), .DDR_ATYPE(DDR_ATYPE), .DDR_AREADY(DDR_AREADY),
    .DDR_AADR(DDR_AADR), .DDR_ALEN(DDR_ALEN), .DDR_ASIZE(DDR_ASIZE), .DDR_ABURST(DDR_ABURST),
    .DDR_WVALID(DDR_WVALID), .DDR_WLAST(DDR_WLAST), .DDR_WREADY(DDR_WREADY),
    .DDR_WDATA(DDR_WDATA), .DDR_WSTRB(DDR_WSTRB),
    .DDR_BVALID(DDR_BVALID), .DDR_BREADY(DDR_BREADY),
    .DDR_RVALID(DDR_RVALID), .DDR_RLAST(DDR_RLAST), .DDR_RDATA(DDR_RDATA),
    .DDR_RREADY(DDR_RREADY)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt = 0;

  // Model of the two FIFOs as the user and DDR target should see them.
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];

  always @(posedge AXI_CLK) if (usr_cmd_ack === 1'b1) ack_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXI_CLK);
    #1;
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      chk("tx_full", tx_buf_full, (wq.size() == WD));
      usr_data_in = d;
      tx_buf_we   = 1'b1;
      tick();
      if (wq.size() < WD) wq.push_back(d);
    end
    tx_buf_we = 1'b0;
  endtask

  task automatic wait_ack(input logic exp_type);
    int t;
    t = 0;
    while (usr_cmd_ack !== 1'b1 && t < 40) begin tick(); t++; end
    chk("cmd_ack", usr_cmd_ack, 1'b1);
    chk("avalid_after_ack", DDR_AVALID, 1'b1);
    chk("atype", DDR_ATYPE, exp_type);
  endtask

  task automatic wr_slave(input logic [AW-1:0] addr, input int alen, input int a_wait,
                          input bit rnd_wready, input bit b_early);
    int beats, t;
    bit done;
    logic [DW-1:0] exp;
    chk("w_aadr", DDR_AADR, addr);
    chk("w_alen", DDR_ALEN, 64'(alen));
    for (int i = 0; i < a_wait; i++) begin
      tick();
      chk("a_hold", {DDR_AVALID, DDR_ATYPE, DDR_AADR}, {1'b1, 1'b1, addr});
    end
    DDR_AREADY = 1'b1;
    tick();
    DDR_AREADY = 1'b0;
    chk("a_drop", DDR_AVALID, 1'b0);
    beats = 0; t = 0; done = 0;
    while (!done && t < 400) begin
      DDR_WREADY = rnd_wready ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("wvalid_hold", DDR_WVALID, 1'b1);
      if (DDR_WREADY) begin
        exp = (wq.size() > 0) ? wq.pop_front() : 'x;
        chk("w_data", DDR_WDATA, exp);
        chk("w_last", DDR_WLAST, (beats == alen));
        if (beats == alen) begin
          done = 1;
          if (b_early) DDR_BVALID = 1'b1;
        end
        beats++;
      end
      tick();
      t++;
    end
    DDR_WREADY = 1'b0;
    chk("w_beats", 64'(beats), 64'(alen + 1));
    chk("w_after_last", {DDR_WVALID, DDR_BREADY, state}, {1'b0, 1'b1, 3'd3});
    if (b_early) begin
      DDR_BVALID = 1'b0;
      tick();
    end else begin
      DDR_BVALID = 1'b1;
      tick();
      DDR_BVALID = 1'b0;
    end
    chk("w_done_pulse", {usr_wr_done, axi_bus_busy, state}, {1'b1, 1'b1, 3'd5});
    tick();
    chk("w_idle", {usr_wr_done, axi_bus_busy, state}, {1'b0, 1'b0, 3'd0});
  endtask

  task automatic rd_slave(input logic [AW-1:0] addr, input int alen, input int n_send,
                          input int last_idx, input bit gaps);
    int t;
    logic [DW-1:0] d;
    chk("r_aadr", DDR_AADR, addr);
    chk("r_alen", DDR_ALEN, 64'(alen));
    DDR_AREADY = 1'b1;
    tick();
    DDR_AREADY = 1'b0;
    chk("r_state", state, 3'd4);
    for (int i = 0; i < n_send; i++) begin
      if (gaps) begin DDR_RVALID = 1'b0; tick(); end
      d = {$urandom, $urandom};
      DDR_RVALID = 1'b1;
      DDR_RDATA  = d;
      DDR_RLAST  = (i == last_idx);
      t = 0;
      while (DDR_RREADY !== 1'b1 && t < 50) begin tick(); t++; end
      chk("rready", DDR_RREADY, 1'b1);
      tick();
      rq.push_back(d);
      if (i == last_idx) break;
    end
    DDR_RVALID = 1'b0;
    DDR_RLAST  = 1'b0;
    chk("r_done_pulse", {usr_wr_done, DDR_RREADY, state}, {1'b1, 1'b0, 3'd5});
    tick();
    chk("r_idle", {usr_wr_done, state}, {1'b0, 3'd0});
  endtask

  task automatic pop_check(input int n);
    logic [DW-1:0] exp;
    for (int i = 0; i < n; i++) begin
      chk("rx_dvalid", rx_buf_dvalid, 1'b1);
      exp = (rq.size() > 0) ? rq.pop_front() : 'x;
      chk("rx_data", usr_data_out, exp);
      rx_buf_re = 1'b1;
      tick();
      rx_buf_re = 1'b0;
    end
    chk("rx_dvalid_end", rx_buf_dvalid, (rq.size() > 0));
  endtask

  initial begin
    logic [AW-1:0] wa, ra;
    int base;
    usr_rstn = 1'b0;
    usr_write = 0; usr_read = 0; usr_waddr_in = '0; usr_raddr_in = '0;
    usr_wd_alen = '0; usr_rd_alen = '0; tx_buf_we = 0; usr_data_in = '0; rx_buf_re = 0;
    DDR_AREADY = 0; DDR_WREADY = 0; DDR_BVALID = 0; DDR_RVALID = 0; DDR_RLAST = 0; DDR_RDATA = '0;
    repeat (3) tick();
    // reset state
    chk("rst_state", {state, axi_bus_busy, usr_wr_done, rlast_err}, 6'b000_000);
    chk("rst_ddr_ctl", {DDR_AVALID, DDR_WVALID, DDR_WLAST, DDR_BREADY, DDR_RREADY}, 5'b0);
    chk("rst_aadr_alen", {DDR_AADR, DDR_ALEN}, '0);
    chk("rst_fifo", {tx_buf_full, rx_buf_dvalid, usr_cmd_ack, usr_cmd_err}, 4'b0);
    chk("asize_aburst", {DDR_ASIZE, DDR_ABURST}, {3'd3, 2'b01});
    chk("wstrb", DDR_WSTRB, 64'hFF);
    usr_rstn = 1'b1;
    tick();

    // 4-beat write, AREADY after 2 cycles, WREADY always high
    push_words(4);
    wa = $urandom; usr_waddr_in = wa; usr_wd_alen = 8'd3; usr_write = 1'b1;
    wait_ack(1'b1);
    usr_write = 1'b0;
    wr_slave(wa, 3, 2, 0, 0);
    // write FIFO must now be empty: a 1-beat write cannot start
    base = ack_cnt; usr_wd_alen = 8'd0; usr_write = 1'b1;
    repeat (5) tick();
    chk("wfifo_empty_no_accept", {64'(ack_cnt - base), 61'd0, state}, '0);
    usr_write = 1'b0;

    // 8-beat read with gaps
    ra = $urandom; usr_raddr_in = ra; usr_rd_alen = 8'd7; usr_read = 1'b1;
    wait_ack(1'b0);
    usr_read = 1'b0;
    rd_slave(ra, 7, 8, 7, 1);
    chk("rlast_ok", rlast_err, 1'b0);
    pop_check(8);

    // 16-beat read blocked by one resident word until it is popped
    ra = $urandom; usr_raddr_in = ra; usr_rd_alen = 8'd0; usr_read = 1'b1;
    wait_ack(1'b0);
    usr_read = 1'b0;
    rd_slave(ra, 0, 1, 0, 0);
    usr_rd_alen = 8'd15; usr_read = 1'b1;
    base = ack_cnt;
    repeat (6) tick();
    chk("rd_space_hold", {64'(ack_cnt - base), 61'd0, state}, '0);
    pop_check(1);
    wait_ack(1'b0);
    usr_read = 1'b0;
    rd_slave(ra, 15, 16, 15, 1);
    chk("rx_full_dvalid", rx_buf_dvalid, 1'b1);
    pop_check(16);

    // oversized requests
    usr_wd_alen = 8'd16; usr_write = 1'b1;
    tick();
    chk("err_wr_over", {usr_cmd_err, usr_cmd_ack, state}, {1'b1, 1'b0, 3'd0});
    usr_write = 1'b0;
    tick();
    chk("err_clear", usr_cmd_err, 1'b0);
    usr_wd_alen = 8'd200; usr_rd_alen = 8'd16; usr_write = 1'b1; usr_read = 1'b1;
    tick();
    chk("err_both_over", {usr_cmd_err, state}, {1'b1, 3'd0});
    usr_write = 1'b0; usr_read = 1'b0;
    tick();

    // fill write FIFO past full, then 16-beat write with random WREADY, early B
    push_words(17);
    chk("tx_full_after", tx_buf_full, 1'b1);
    wa = $urandom; usr_waddr_in = wa; usr_wd_alen = 8'd15; usr_write = 1'b1;
    wait_ack(1'b1);
    usr_write = 1'b0;
    wr_slave(wa, 15, $urandom_range(0, 3), 1, 1);

    // write and read together: write first, read right after
    push_words(2);
    wa = $urandom; ra = $urandom;
    usr_waddr_in = wa; usr_wd_alen = 8'd1; usr_raddr_in = ra; usr_rd_alen = 8'd1;
    usr_write = 1'b1; usr_read = 1'b1;
    wait_ack(1'b1);
    usr_write = 1'b0;
    wr_slave(wa, 1, 0, 0, 0);
    wait_ack(1'b0);
    usr_read = 1'b0;
    rd_slave(ra, 1, 2, 1, 0);
    pop_check(2);

    // early RLAST: alen=3, RLAST on beat 2
    ra = $urandom; usr_raddr_in = ra; usr_rd_alen = 8'd3; usr_read = 1'b1;
    wait_ack(1'b0);
    usr_read = 1'b0;
    rd_slave(ra, 3, 4, 1, 0);
    chk("rlast_early_err", rlast_err, 1'b1);
    pop_check(2);
    chk("rlast_sticky", rlast_err, 1'b1);

    // reset mid write burst
    push_words(4);
    usr_waddr_in = $urandom; usr_wd_alen = 8'd3; usr_write = 1'b1;
    wait_ack(1'b1);
    usr_write = 1'b0;
    DDR_AREADY = 1'b1; tick(); DDR_AREADY = 1'b0;
    DDR_WREADY = 1'b1; tick();
    usr_rstn = 1'b0;
    #1;
    chk("midrst_state", {state, axi_bus_busy, rlast_err}, 5'b0);
    chk("midrst_ddr", {DDR_AVALID, DDR_WVALID, DDR_BREADY, DDR_RREADY, tx_buf_full, rx_buf_dvalid}, 6'b0);
    wq.delete(); rq.delete();
    DDR_WREADY = 1'b0;
    tick(); tick();
    usr_rstn = 1'b1;
    tick();
    base = ack_cnt; usr_wd_alen = 8'd0; usr_write = 1'b1;
    repeat (5) tick();
    chk("midrst_wfifo_flushed", {64'(ack_cnt - base), 61'd0, state}, '0);
    usr_write = 1'b0;

    // missing RLAST: alen=1, no RLAST on either beat
    ra = $urandom; usr_raddr_in = ra; usr_rd_alen = 8'd1; usr_read = 1'b1;
    wait_ack(1'b0);
    usr_read = 1'b0;
    rd_slave(ra, 1, 2, -1, 1);
    chk("rlast_missing_err", rlast_err, 1'b1);
    pop_check(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
